// File: rtl/col_parity_func_if.sv
// ---------------------------------------------------------------------------
// col_parity_func_if
//   Bus between the theta engine, the slice memory and the result writer.
//   master : controller/memory side (drives start, returns line_in)
//   slave  : col_parity_func (drives address, write strobe/data, done flag)
//   Signals:
//     start        level request to begin a pass
//     line_in      25-bit slice read back from memory at (cnt_value-1) mod 64
//     cnt_value    6-bit slice read counter / memory address
//     write_enable one-cycle strobe per theta-transformed slice
//     write_value  theta result slice, valid while write_enable is high
//     donee        pass complete flag
// ---------------------------------------------------------------------------
interface col_parity_func_if;
    logic        start;
    logic [24:0] line_in;
    logic [5:0]  cnt_value;
    logic        write_enable;
    logic [24:0] write_value;
    logic        donee;

    modport master (
        output start,
        output line_in,
        input  cnt_value,
        input  write_enable,
        input  write_value,
        input  donee
    );

    modport slave (
        input  start,
        input  line_in,
        output cnt_value,
        output write_enable,
        output write_value,
        output donee
    );
endinterface

// File: rtl/col_parity_func.sv
// ---------------------------------------------------------------------------
// col_parity_func
//   Keccak theta (column-parity) step over a 5x5x64 state stored as 64
//   25-bit slices in an external memory. Walks slices 0..63, emitting one
//   write strobe per transformed slice, then raises donee.
//   Ports:
//     clk  in  clock, rising edge
//     rst  in  asynchronous active-low reset
//     bus  slave modport of col_parity_func_if (start, line_in in;
//          cnt_value, write_enable, write_value, donee out)
//   Slice bit map: bit[5*y+x] = lane (x,y).
// ---------------------------------------------------------------------------
module col_parity_func (
    input  logic               clk,
    input  logic               rst,
    col_parity_func_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        CALC,
        WRITE,
        DONE
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_we;
    logic [24:0] r_wv;
    logic        r_done;
    logic [4:0]  r_prev_c;   // column parities of the previous slice (z-1)

    logic [4:0]  w_col;
    logic [24:0] w_theta;

    // Column parity of the current slice and the theta result using the
    // registered parity of slice z-1.
    always_comb begin
        w_col   = '0;
        w_theta = '0;
        for (int unsigned x = 0; x < 5; x++) begin
            for (int unsigned y = 0; y < 5; y++) begin
                w_col[x] = w_col[x] ^ bus.line_in[5*y+x];
            end
        end
        for (int unsigned x = 0; x < 5; x++) begin
            for (int unsigned y = 0; y < 5; y++) begin
                w_theta[5*y+x] = bus.line_in[5*y+x]
                               ^ w_col[(x+4)%5]
                               ^ r_prev_c[(x+1)%5];
            end
        end
    end

    // The strobe is set on the CALC edge so it is high exactly for the
    // WRITE state; WRITE always clears it, guaranteeing a low gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_wv     <= '0;
            r_done   <= 1'b0;
            r_prev_c <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    r_we  <= 1'b0;
                    if (bus.start) begin
                        r_state <= PRIME;
                    end
                end
                PRIME: begin
                    // cnt=0 here, so line_in is slice 63: seed z-1 parity
                    r_prev_c <= w_col;
                    r_cnt    <= 6'd1;
                    r_state  <= CALC;
                end
                CALC: begin
                    r_wv     <= w_theta;
                    r_prev_c <= w_col;
                    r_we     <= 1'b1;
                    r_state  <= WRITE;
                end
                WRITE: begin
                    r_we <= 1'b0;
                    if (r_cnt == '0) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt   <= r_cnt + 6'd1;
                        r_state <= CALC;
                    end
                end
                DONE: begin
                    r_we  <= 1'b0;
                    r_cnt <= '0;
                    if (!bus.start) begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cnt_value    = r_cnt;
    assign bus.write_enable = r_we;
    assign bus.write_value  = r_wv;
    assign bus.donee        = r_done;

endmodule

// File: tb/tb_col_parity_func.sv
module tb_col_parity_func;

    logic clk;
    logic rst;

    col_parity_func_if ifc ();

    col_parity_func dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slice memory model: returns mem[(cnt_value-1) mod 64]
    logic [24:0] mem [64];
    logic [5:0]  w_addr;
    assign w_addr      = ifc.cnt_value - 6'd1;
    assign ifc.line_in = mem[w_addr];

    logic [24:0] exp_tab [64];
    logic [24:0] q [$];

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 64; i++) begin
            mem[i]     = '0;
            exp_tab[i] = '0;
        end
    endtask

    task automatic push_expected();
        for (int i = 0; i < 64; i++) q.push_back(exp_tab[i]);
    endtask

    // Monitor: compares each strobe against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            if (ifc.write_enable) begin
                check("we_gap", {31'd0, prev_we}, 32'd0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got value %h with no expected entry at %0t",
                             ifc.write_value, $time);
                end else begin
                    logic [24:0] e;
                    e = q.pop_front();
                    check("write_value", {7'd0, ifc.write_value}, {7'd0, e});
                end
                pulses++;
            end
            prev_we = ifc.write_enable;
        end else begin
            prev_we = 1'b0;
        end
    end

    // Starts a pass and checks its timing, pulse count and final state.
    task automatic run_pass();
        int n;
        int first;
        int p0;
        n     = 0;
        first = 0;
        p0    = pulses;
        @(negedge clk);
        ifc.start = 1'b1;
        while (!ifc.donee && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (first == 0 && ifc.write_enable) first = n;
        end
        check("first_pulse_edge", first, 3);
        check("done_edge", n, 130);
        @(negedge clk);
        #1;
        check("pulse_count", pulses - p0, 64);
        check("queue_empty", q.size(), 0);
        check("cnt_at_done", {26'd0, ifc.cnt_value}, 32'd0);
        check("donee_high", {31'd0, ifc.donee}, 32'd1);
    endtask

    // Holds start high in DONE, then drops it and checks the return to IDLE.
    task automatic end_pass(input int hold);
        int p0;
        p0 = pulses;
        repeat (hold) @(posedge clk);
        #1;
        check("done_hold_no_pulses", pulses - p0, 0);
        check("done_hold_donee", {31'd0, ifc.donee}, 32'd1);
        @(negedge clk);
        ifc.start = 1'b0;
        @(posedge clk);
        #1;
        check("donee_drop", {31'd0, ifc.donee}, 32'd0);
        check("idle_we", {31'd0, ifc.write_enable}, 32'd0);
    endtask

    initial begin
        int n;
        rst       = 1'b0;
        ifc.start = 1'b0;
        clear_tables();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cnt", {26'd0, ifc.cnt_value}, 32'd0);
        check("rst_we", {31'd0, ifc.write_enable}, 32'd0);
        check("rst_wv", {7'd0, ifc.write_value}, 32'd0);
        check("rst_donee", {31'd0, ifc.donee}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // All-zero memory
        clear_tables();
        push_expected();
        run_pass();
        end_pass(2);

        // Single bit at slice 0
        clear_tables();
        mem[0]     = 25'h0000001;
        exp_tab[0] = 25'h0210843;
        exp_tab[1] = 25'h1084210;
        push_expected();
        run_pass();
        end_pass(2);

        // Wrap-around: single bit at slice 63
        clear_tables();
        mem[63]     = 25'h0000001;
        exp_tab[0]  = 25'h1084210;
        exp_tab[63] = 25'h0210843;
        push_expected();
        run_pass();
        end_pass(2);

        // Even column parity; start held past donee
        clear_tables();
        mem[5]     = 25'h0000021;
        exp_tab[5] = 25'h0000021;
        push_expected();
        run_pass();
        end_pass(20);

        // Second pass after start low->high
        push_expected();
        run_pass();
        end_pass(2);

        // Reset mid-pass after the 10th pulse (slice 9 is nonzero)
        clear_tables();
        mem[9]      = 25'h0000001;
        exp_tab[9]  = 25'h0210843;
        exp_tab[10] = 25'h1084210;
        push_expected();
        pulses = 0;
        @(negedge clk);
        ifc.start = 1'b1;
        n = 0;
        while (pulses < 10 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("reach_pulse10", pulses, 10);
        rst = 1'b0;
        #1;
        check("abort_cnt", {26'd0, ifc.cnt_value}, 32'd0);
        check("abort_we", {31'd0, ifc.write_enable}, 32'd0);
        check("abort_wv", {7'd0, ifc.write_value}, 32'd0);
        check("abort_donee", {31'd0, ifc.donee}, 32'd0);
        q.delete();
        ifc.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        push_expected();
        run_pass();
        end_pass(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
